kalman_ab_tracker: RTL and testbench

KALMAN_AB_TRACKER -- requirements
Module: kalman_ab_tracker

---
 rtl/kalman_pkg.sv | 21 ++
 rtl/kalman_fx_mul.sv | 40 ++++
 rtl/kalman_ab_tracker.sv | 215 +++++++++++++++++++++
 tb/tb_kalman_ab_tracker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// Shared definitions for the alpha-beta tracker: FSM states, default word format
// and fixed-point constants.
package kalman_pkg;

    localparam int ARCH_W_DEF = 32;
    localparam int ARCH_F_DEF = 15;

    localparam logic signed [ARCH_W_DEF-1:0] FX_ONE  = 32'sh0000_8000;
    localparam logic signed [ARCH_W_DEF-1:0] FX_ZERO = 32'sh0000_0000;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        PRED  = 3'd2,
        RESID = 3'd3,
        UPD_X = 3'd4,
        UPD_V = 3'd5,
        DONE  = 3'd6
    } kalman_state_e;

endpackage

// File: rtl/kalman_fx_mul.sv
// Combinational signed Q(F) multiply: full-width product, floor shift by F.
// Saturates to the signed W range when KALMAN_AB_SAT_EN is defined, else wraps.
module kalman_fx_mul
    import kalman_pkg::*;
#(
    parameter int W = ARCH_W_DEF,
    parameter int F = ARCH_F_DEF
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] p_o
);

    logic signed [2*W-1:0] full_s;

    assign full_s = a_i * b_i;

`ifdef KALMAN_AB_SAT_EN
    localparam logic signed [W-1:0] P_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] P_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [2*W-1:0] shr_s;

    // Clamp when the bits above the result's sign differ from it.
    always_comb begin
        shr_s = full_s >>> F;
        if ((&shr_s[2*W-1:W-1]) || !(|shr_s[2*W-1:W-1])) begin
            p_o = shr_s[W-1:0];
        end else begin
            p_o = shr_s[2*W-1] ? P_MIN : P_MAX;
        end
    end
`else
    // Wrapping result: low W bits of the shifted product.
    always_comb begin
        p_o = W'(full_s >>> F);
    end
`endif

endmodule

// File: rtl/kalman_ab_tracker.sv
// Multi-channel alpha-beta tracker sharing one fixed-point multiplier across channels.
// Optional saturation of arithmetic and output clamp: define KALMAN_AB_SAT_EN.
module kalman_ab_tracker
    import kalman_pkg::*;
#(
    parameter int DISP_WIDTH = 11,
    parameter int NUM_CH     = 2,
    parameter int ARCH_W     = ARCH_W_DEF,
    parameter int ARCH_F     = ARCH_F_DEF,
    parameter int TSTEP_FI   = int'(FX_ONE),
    parameter int ALPHA_FI   = 16384,
    parameter int BETA_FI    = 8192
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [NUM_CH*DISP_WIDTH-1:0] z,
    input  logic                         valid,
    input  logic                         seed,
    output logic                         ready,
    output logic [NUM_CH*DISP_WIDTH-1:0] z_new,
    output logic                         z_new_valid
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic signed [ARCH_W-1:0] TSTEP_C = ARCH_W'(TSTEP_FI);
    localparam logic signed [ARCH_W-1:0] ALPHA_C = ARCH_W'(ALPHA_FI);
    localparam logic signed [ARCH_W-1:0] BETA_C  = ARCH_W'(BETA_FI);
    localparam logic signed [ARCH_W-1:0] ZERO_C  = ARCH_W'(FX_ZERO);
`ifdef KALMAN_AB_SAT_EN
    localparam logic signed [ARCH_W-1:0] W_MAX = {1'b0, {(ARCH_W-1){1'b1}}};
    localparam logic signed [ARCH_W-1:0] W_MIN = {1'b1, {(ARCH_W-1){1'b0}}};
`endif

    kalman_state_e state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [NUM_CH*DISP_WIDTH-1:0] zcap_q;
    logic seed_q, first_q, ready_q, zv_q;
    logic [NUM_CH*DISP_WIDTH-1:0] z_new_q;
    logic signed [ARCH_W-1:0] x_q [NUM_CH];
    logic signed [ARCH_W-1:0] v_q [NUM_CH];
    logic signed [ARCH_W-1:0] xp_q, r_q;

    logic [DISP_WIDTH-1:0] z_ch_s;
    logic signed [ARCH_W-1:0] zq_s, mul_a_s, mul_b_s, mul_p_s;
    logic skip_s;
    logic [NUM_CH*DISP_WIDTH-1:0] z_out_s;

    function automatic logic signed [ARCH_W-1:0] fx_sum(
        input logic signed [ARCH_W-1:0] a_s,
        input logic signed [ARCH_W-1:0] b_s,
        input logic                     sub_s
    );
        logic [ARCH_W:0] s_s;
        if (sub_s) begin
            s_s = {a_s[ARCH_W-1], a_s} - {b_s[ARCH_W-1], b_s};
        end else begin
            s_s = {a_s[ARCH_W-1], a_s} + {b_s[ARCH_W-1], b_s};
        end
`ifdef KALMAN_AB_SAT_EN
        if (s_s[ARCH_W] != s_s[ARCH_W-1]) begin
            fx_sum = s_s[ARCH_W] ? W_MIN : W_MAX;
        end else begin
            fx_sum = s_s[ARCH_W-1:0];
        end
`else
        fx_sum = s_s[ARCH_W-1:0];
`endif
    endfunction

    kalman_fx_mul #(.W(ARCH_W), .F(ARCH_F)) u_mul (
        .a_i (mul_a_s),
        .b_i (mul_b_s),
        .p_o (mul_p_s)
    );

    // FSM state and channel counter register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= INIT;
            ch_q    <= {CH_W{1'b0}};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Next-state logic; channel loop repeats PRED..UPD_V once per channel.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            INIT:  state_d = IDLE;
            IDLE: begin
                if (valid && ready_q) begin
                    state_d = PRED;
                    ch_d    = {CH_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            PRED:  state_d = RESID;
            RESID: state_d = UPD_X;
            UPD_X: state_d = UPD_V;
            UPD_V: begin
                if (ch_q == CH_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = PRED;
                    ch_d    = ch_q + CH_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Operand selection for the single shared multiplier, plus the scaled measurement.
    always_comb begin
        z_ch_s  = zcap_q[ch_q*DISP_WIDTH +: DISP_WIDTH];
        zq_s    = {{(ARCH_W-DISP_WIDTH){1'b0}}, z_ch_s} << ARCH_F;
        skip_s  = seed_q || first_q;
        mul_a_s = ZERO_C;
        mul_b_s = ZERO_C;
        case (state_q)
            PRED: begin
                mul_a_s = TSTEP_C;
                mul_b_s = v_q[ch_q];
            end
            UPD_X: begin
                mul_a_s = ALPHA_C;
                mul_b_s = r_q;
            end
            UPD_V: begin
                mul_a_s = BETA_C;
                mul_b_s = r_q;
            end
            default: begin
                mul_a_s = ZERO_C;
                mul_b_s = ZERO_C;
            end
        endcase
    end

    // Integer pixel position per channel from the Q-format track state.
    always_comb begin
        z_out_s = {(NUM_CH*DISP_WIDTH){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef KALMAN_AB_SAT_EN
            if (x_q[c][ARCH_W-1]) begin
                z_out_s[c*DISP_WIDTH +: DISP_WIDTH] = {DISP_WIDTH{1'b0}};
            end else if (|x_q[c][ARCH_W-2:ARCH_F+DISP_WIDTH]) begin
                z_out_s[c*DISP_WIDTH +: DISP_WIDTH] = {DISP_WIDTH{1'b1}};
            end else begin
                z_out_s[c*DISP_WIDTH +: DISP_WIDTH] = x_q[c][ARCH_F +: DISP_WIDTH];
            end
`else
            z_out_s[c*DISP_WIDTH +: DISP_WIDTH] = x_q[c][ARCH_F +: DISP_WIDTH];
`endif
        end
    end

    // Track datapath: capture on acceptance, then one arithmetic step per state.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            zcap_q  <= {(NUM_CH*DISP_WIDTH){1'b0}};
            seed_q  <= 1'b0;
            first_q <= 1'b1;
            xp_q    <= {ARCH_W{1'b0}};
            r_q     <= {ARCH_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                x_q[c] <= {ARCH_W{1'b0}};
                v_q[c] <= {ARCH_W{1'b0}};
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid && ready_q) begin
                        zcap_q <= z;
                        seed_q <= seed;
                    end
                end
                PRED:  xp_q <= skip_s ? zq_s : fx_sum(x_q[ch_q], mul_p_s, 1'b0);
                RESID: r_q  <= fx_sum(zq_s, xp_q, 1'b1);
                UPD_X: x_q[ch_q] <= skip_s ? zq_s : fx_sum(xp_q, mul_p_s, 1'b0);
                UPD_V: v_q[ch_q] <= skip_s ? ZERO_C : fx_sum(v_q[ch_q], mul_p_s, 1'b0);
                DONE:  first_q <= 1'b0;
                default: begin
                end
            endcase
        end
    end

    // Registered outputs; ready waits one extra cycle after INIT.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q <= 1'b0;
            zv_q    <= 1'b0;
            z_new_q <= {(NUM_CH*DISP_WIDTH){1'b0}};
        end else begin
            ready_q <= (state_d == IDLE) && (state_q != INIT);
            zv_q    <= (state_q == DONE);
            if (state_q == DONE) begin
                z_new_q <= z_out_s;
            end else begin
                z_new_q <= z_new_q;
            end
        end
    end

    assign ready       = ready_q;
    assign z_new       = z_new_q;
    assign z_new_valid = zv_q;

endmodule

// File: tb/tb_kalman_ab_tracker.sv
// Scoreboard bench for kalman_ab_tracker (NUM_CH=2, default gains) with a
// real-number-free reference model of the alpha-beta update rules.
module tb_kalman_ab_tracker;

    localparam int D   = 11;
    localparam int NCH = 2;
    localparam int ZW  = NCH * D;
    localparam int LAT = 4 * NCH + 1;
    localparam longint TSTEP = 32768;
    localparam longint ALPHA = 16384;
    localparam longint BETA  = 8192;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic [ZW-1:0] z = '0;
    logic valid = 1'b0;
    logic seed = 1'b0;
    logic ready;
    logic [ZW-1:0] z_new;
    logic z_new_valid;

    kalman_ab_tracker #(
        .DISP_WIDTH(11), .NUM_CH(2), .ARCH_W(32), .ARCH_F(15),
        .TSTEP_FI(32768), .ALPHA_FI(16384), .BETA_FI(8192)
    ) dut (
        .clk(clk), .aresetn(aresetn), .z(z), .valid(valid), .seed(seed),
        .ready(ready), .z_new(z_new), .z_new_valid(z_new_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ZW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [ZW-1:0] last_z = '0;

    longint mx[NCH];
    longint mv[NCH];
    bit mfirst = 1'b1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Fit a wide intermediate to the 32-bit signed word.
    function automatic longint fit(input longint a);
`ifdef KALMAN_AB_SAT_EN
        if (a > 64'sd2147483647) return 64'sd2147483647;
        else if (a < -64'sd2147483648) return -64'sd2147483648;
        else return a;
`else
        int t;
        t = int'(a);
        return longint'(t);
`endif
    endfunction

    function automatic longint qmul(input longint k, input longint a);
        return fit((k * a) >>> 15);
    endfunction

    function automatic longint pix(input longint x);
        longint p;
        p = x >>> 15;
`ifdef KALMAN_AB_SAT_EN
        if (p < 0) return 0;
        else if (p > 2047) return 2047;
        else return p;
`else
        return p & 64'sd2047;
`endif
    endfunction

    function automatic logic [ZW-1:0] pk(input int a, input int b);
        logic [ZW-1:0] t;
        t[D-1:0]   = a[D-1:0];
        t[2*D-1:D] = b[D-1:0];
        return t;
    endfunction

    task automatic model_accept(input logic [ZW-1:0] zv, input logic sd);
        exp_t e;
        longint zq, xp, r, p;
        for (int c = 0; c < NCH; c++) begin
            zq = longint'(zv[c*D +: D]) * 32768;
            if (sd || mfirst) begin
                mx[c] = zq;
                mv[c] = 0;
            end else begin
                xp    = fit(mx[c] + qmul(TSTEP, mv[c]));
                r     = fit(zq - xp);
                mx[c] = fit(xp + qmul(ALPHA, r));
                mv[c] = fit(mv[c] + qmul(BETA, r));
            end
            p = pix(mx[c]);
            e.val[c*D +: D] = p[D-1:0];
        end
        mfirst = 1'b0;
        e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
    endtask

    task automatic send(input logic [ZW-1:0] zv, input logic sd, input bit hold);
        logic [31:0] r;
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (ready) begin
                z = zv; seed = sd; valid = 1'b1;
                model_accept(zv, sd);
                @(posedge clk);
                #1;
                r = $urandom;
                z = r[ZW-1:0]; seed = r[31]; valid = hold;
                done = 1'b1;
            end else begin
                n++;
                r = $urandom;
                z = r[ZW-1:0]; seed = r[31]; valid = hold;
                if (n > 40) begin
                    checks++; errors++;
                    $display("FAIL ready_timeout ready=%0b after %0d cycles, required 1", ready, n);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid = ready ? 1'b0 : hold;
        end
    endtask

    task automatic chk(input string name, input logic [ZW-1:0] got, input logic [ZW-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic reset_seq();
        aresetn = 1'b0; valid = 1'b0;
        #1;
        chk("rst_z_new", z_new, '0);
        chk("rst_z_new_valid", ZW'(z_new_valid), '0);
        chk("rst_ready", ZW'(ready), '0);
        sb.delete();
        for (int c = 0; c < NCH; c++) begin
            mx[c] = 0; mv[c] = 0;
        end
        mfirst = 1'b1;
        last_z = '0;
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        chk("ready_after_1_edge", ZW'(ready), '0);
        @(negedge clk);
        chk("ready_after_2_edges", ZW'(ready), ZW'(1));
    endtask

    // Monitor: pops the scoreboard on each output pulse and watches hold/busy behaviour.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (aresetn) begin
                if (z_new_valid) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pulse got z_new=%h with no pending acceptance", z_new);
                    end else begin
                        e = sb.pop_front();
                        chk("z_new", z_new, e.val);
                        chk("pulse_cycle", ZW'(cyc), ZW'(e.cyc));
                        chk("ready_at_pulse", ZW'(ready), ZW'(1));
                        last_z = e.val;
                    end
                end else begin
                    chk("z_new_hold", z_new, last_z);
                end
                if (sb.size() > 0 && cyc >= sb[0].cyc - LAT && cyc < sb[0].cyc) begin
                    chk("ready_busy", ZW'(ready), '0);
                end
            end
        end
    end

    initial begin
        int n;
        reset_seq();
        send(pk(100, 200), 1'b0, 1'b0);
        send(pk(120, 200), 1'b0, 1'b1);
        send(pk(120, 200), 1'b0, 1'b1);
        send(pk(10, 10), 1'b1, 1'b0);
        send(pk(0, 0), 1'b0, 1'b1);
        send(pk(0, 0), 1'b0, 1'b0);
        send(pk(0, 0), 1'b0, 1'b0);
        idle(3, 1'b0);
        send(pk(500, 600), 1'b1, 1'b0);
        send(pk(510, 590), 1'b0, 1'b0);
        send(pk(300, 400), 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset_seq();
        send(pk(700, 800), 1'b0, 1'b0);
        send(pk(710, 780), 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            logic [31:0] r;
            r = $urandom;
            idle(int'(r[1:0]), r[2]);
            send(r[ZW+3:4], ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, r[3]);
        end
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            if (ready) valid = 1'b0;
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
        end
        idle(3, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
